// File: rtl/iq_packer_pkg.sv
// rtl/iq_packer_pkg.sv - shared widths and gearbox phase encodings for the I/Q sample packer
//
// Purpose: one place for the sample/word geometry of the packer. Four 12-bit
// I/Q pairs (96 bits) fill exactly three 32-bit words, called a group.
// Contents: SAMPLE_W, WORD_W, PAIR_W, PAIRS_PER_GROUP, WORDS_PER_GROUP,
// sample_t/word_t/pair_t typedefs and the PH0..PH3 phase constants.
package iq_packer_pkg;

  localparam int SAMPLE_W        = 12;
  localparam int WORD_W          = 32;
  localparam int PAIR_W          = 2 * SAMPLE_W;
  localparam int PAIRS_PER_GROUP = 4;
  localparam int WORDS_PER_GROUP = 3;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [PAIR_W-1:0]   pair_t;

  // Position of the next accepted pair inside its group.
  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock show-ahead FIFO with occupancy output
//
// Purpose: word buffer between the packer gearbox and the Packetizer. The head
// word is presented combinationally on rd_data whenever the FIFO is non-empty.
// Ports:
//   clk      in   1      clock
//   rstn     in   1      asynchronous active-low reset (pointers and level)
//   wr_en    in   1      push wr_data; ignored when full and not popping
//   wr_data  in   DW     word to push
//   rd_en    in   1      pop the head; ignored when empty
//   rd_data  out  DW     head word, zero while empty
//   rd_dr    out  1      FIFO non-empty
//   level    out  AW+1   words currently stored
module sync_fifo_fwft #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_dr,
  output logic [AW:0]   level
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign pop  = rd_en && (level != '0);
  // A push into a full FIFO is allowed when the head leaves on the same edge.
  assign push = wr_en && ((level != DEPTH_L) || pop);

  // Storage is not reset so it can map onto RAM; rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign rd_dr   = (level != '0);
  assign rd_data = rd_dr ? mem[rd_ptr] : '0;

endmodule

// File: rtl/iq_sample_packer.sv
// rtl/iq_sample_packer.sv - packs 12-bit I/Q pairs MSB-first into 32-bit words behind a show-ahead FIFO
//
// Purpose: gearbox (4 pairs -> 3 words), whole-group admission against FIFO
// free space, drop statistics, and the output FIFO drained by the Packetizer.
// Optional build macro: IQ_PACKER_TEST_PATTERN_EN adds test_en and a ramp
// generator (I=ramp, Q=~ramp) that replaces accepted samples.
// Ports:
//   clk       in   1          clock
//   rstn      in   1          asynchronous active-low reset
//   enable    in   1          0 idles the packer and realigns to group start
//   in_valid  in   1          I/Q pair present
//   in_i      in   12         I sample
//   in_q      in   12         Q sample
//   test_en   in   1          (IQ_PACKER_TEST_PATTERN_EN only) use ramp pattern
//   rd_en     in   1          pop FIFO head
//   rd_data   out  32         FIFO head (show-ahead)
//   rd_dr     out  1          FIFO non-empty
//   rd_level  out  FIFO_AW+1  words in FIFO
//   overflow  out  1          sticky group-drop flag
//   drop_cnt  out  CNT_W      dropped pairs, saturating
//   clr_stat  in   1          clear overflow and drop_cnt
module iq_sample_packer
  import iq_packer_pkg::*;
#(
  parameter int FIFO_AW = 9,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               enable,
  input  logic               in_valid,
  input  logic [11:0]        in_i,
  input  logic [11:0]        in_q,
`ifdef IQ_PACKER_TEST_PATTERN_EN
  input  logic               test_en,
`endif
  input  logic               rd_en,
  output logic [31:0]        rd_data,
  output logic               rd_dr,
  output logic [FIFO_AW:0]   rd_level,
  output logic               overflow,
  output logic [CNT_W-1:0]   drop_cnt,
  input  logic               clr_stat
);

  localparam logic [FIFO_AW:0] DEPTH_L     = (FIFO_AW+1)'(1 << FIFO_AW);
  localparam logic [FIFO_AW:0] GROUP_WORDS = (FIFO_AW+1)'(WORDS_PER_GROUP);

  logic [1:0]       phase;
  pair_t            acc;
  logic             admit_r;
  logic             accept;
  logic             room_ok;
  logic             admit_now;
  logic             drop;
  logic             wr_en;
  word_t            wr_word;
  pair_t            acc_next;
  sample_t          s_i;
  sample_t          s_q;
  logic [FIFO_AW:0] free_words;
  logic [CNT_W-1:0] cnt_base;

  assign accept = enable && in_valid;

  // ---------------------------------------------------------------- sample source
`ifdef IQ_PACKER_TEST_PATTERN_EN
  sample_t ramp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ramp <= '0;
    end else if (!enable) begin
      ramp <= '0;
    end else if (in_valid) begin
      ramp <= ramp + SAMPLE_W'(1);
    end
  end

  assign s_i = test_en ? ramp  : in_i;
  assign s_q = test_en ? ~ramp : in_q;
`else
  assign s_i = in_i;
  assign s_q = in_q;
`endif

  // ---------------------------------------------------------------- admission
  // The decision is taken once per group, on its first pair, from the registered
  // level. Later pairs of the group follow it, so words are never split.
  assign free_words = DEPTH_L - rd_level;
  assign room_ok    = (free_words >= GROUP_WORDS);
  assign admit_now  = (phase == PH0) ? room_ok : admit_r;
  assign drop       = accept && !admit_now;
  assign wr_en      = accept && admit_now && (phase != PH0);

  // ---------------------------------------------------------------- gearbox
  // acc holds the bits not yet emitted, right-aligned: 24 after ph0, 16 after
  // ph1, 8 after ph2, none after ph3.
  always_comb begin
    wr_word  = '0;
    acc_next = '0;
    case (phase)
      PH0: begin
        acc_next = {s_i, s_q};
      end
      PH1: begin
        wr_word  = {acc[23:0], s_i[11:4]};
        acc_next = {8'd0, s_i[3:0], s_q};
      end
      PH2: begin
        wr_word  = {acc[15:0], s_i, s_q[11:8]};
        acc_next = {16'd0, s_q[7:0]};
      end
      default: begin
        wr_word  = {acc[7:0], s_i, s_q};
        acc_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase   <= PH0;
      acc     <= '0;
      admit_r <= 1'b0;
    end else if (!enable) begin
      phase   <= PH0;
      acc     <= '0;
      admit_r <= 1'b0;
    end else if (in_valid) begin
      phase   <= phase + 2'd1;
      acc     <= acc_next;
      admit_r <= admit_now;
    end
  end

  // ---------------------------------------------------------------- statistics
  // Clear first, then this cycle's drop, so clear+drop leaves a count of one.
  assign cnt_base = clr_stat ? '0 : drop_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      overflow <= (overflow && !clr_stat) || drop;
      if (drop && (cnt_base != '1)) begin
        drop_cnt <= cnt_base + CNT_W'(1);
      end else begin
        drop_cnt <= cnt_base;
      end
    end
  end

  // ---------------------------------------------------------------- output FIFO
  sync_fifo_fwft #(
    .AW (FIFO_AW),
    .DW (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .rd_dr   (rd_dr),
    .level   (rd_level)
  );

endmodule

// File: tb/tb_iq_sample_packer.sv
// tb/tb_iq_sample_packer.sv - self-checking bench for iq_sample_packer with a group-level reference model
module tb_iq_sample_packer;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic        in_valid;
  logic [11:0] in_i;
  logic [11:0] in_q;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_dr;
  logic [AW:0] rd_level;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        clr_stat;
`ifdef IQ_PACKER_TEST_PATTERN_EN
  logic        test_en;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: FIFO as a queue, the current group as a 96-bit bitstream.
  logic [31:0] mq[$];
  int          m_phase;
  bit          m_admit;
  logic [95:0] m_grp;
  logic [15:0] m_drop;
  bit          m_ovf;
  logic [11:0] m_ramp;
  bit          m_tp;

  iq_sample_packer #(
    .FIFO_AW (AW),
    .CNT_W   (16)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .enable   (enable),
    .in_valid (in_valid),
    .in_i     (in_i),
    .in_q     (in_q),
`ifdef IQ_PACKER_TEST_PATTERN_EN
    .test_en  (test_en),
`endif
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_dr    (rd_dr),
    .rd_level (rd_level),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .clr_stat (clr_stat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_phase = 0;
    m_admit = 0;
    m_grp   = '0;
    m_drop  = '0;
    m_ovf   = 0;
    m_ramp  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn     = 1'b0;
    enable   = 1'b1;
    in_valid = 1'b0;
    rd_en    = 1'b0;
    clr_stat = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // One clock: drive inputs, advance the model with the pre-edge state, return at negedge.
  task automatic step(input bit en, input bit v, input logic [11:0] i, input logic [11:0] q,
                      input bit rd, input bit clr);
    int          pre;
    bit          do_pop;
    bit          do_push;
    bit          do_drop;
    logic [31:0] w;
    logic [11:0] pi;
    logic [11:0] pq;
    enable   = en;
    in_valid = v;
    in_i     = i;
    in_q     = q;
    rd_en    = rd;
    clr_stat = clr;
    @(posedge clk);
    pre     = mq.size();
    do_pop  = rd && (pre > 0);
    do_push = 0;
    do_drop = 0;
    w       = '0;
    pi      = m_tp ? m_ramp : i;
    pq      = m_tp ? ~m_ramp : q;
    if (!en) begin
      m_phase = 0;
      m_admit = 0;
      m_grp   = '0;
      m_ramp  = '0;
    end else if (v) begin
      if (m_phase == 0) begin
        m_admit = (DEPTH - pre) >= 3;
        m_grp   = '0;
      end
      m_grp = m_grp | ({72'd0, pi, pq} << (72 - 24 * m_phase));
      if (!m_admit) begin
        do_drop = 1;
      end else if (m_phase > 0) begin
        do_push = 1;
        w = m_grp[95 - 32 * (m_phase - 1) -: 32];
      end
      m_ramp  = m_ramp + 12'd1;
      m_phase = (m_phase + 1) % 4;
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(w);
    if (clr) begin
      m_drop = '0;
      m_ovf  = 0;
    end
    if (do_drop) begin
      m_ovf = 1;
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rd_en    = 1'b0;
    clr_stat = 1'b0;
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    enable   = 1'b1;
    in_valid = 1'b1;
    in_i     = 12'hABC;
    in_q     = 12'h123;
    rd_en    = 1'b0;
    clr_stat = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (rd_dr !== 1'b0) begin failures++; $display("FAIL reset_rd_dr got=%0b exp=0", rd_dr); end
    checks++; if (rd_level !== '0) begin failures++; $display("FAIL reset_rd_level got=%0d exp=0", rd_level); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    checks++; if (drop_cnt !== '0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    in_valid = 1'b0;
    rstn     = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_packing();
    logic [11:0] ti[4];
    logic [11:0] tq[4];
    logic [31:0] exp_w[3];
    ti = '{12'h123, 12'h789, 12'hDEF, 12'h345};
    tq = '{12'h456, 12'hABC, 12'h012, 12'h678};
    exp_w = '{32'h12345678, 32'h9ABCDEF0, 32'h12345678};
    do_reset();
    step(1, 1, ti[0], tq[0], 0, 0);
    checks++; if (rd_level !== 4'd0) begin failures++; $display("FAIL pack_ph0_level got=%0d exp=0", rd_level); end
    step(1, 1, ti[1], tq[1], 0, 0);
    checks++; if (rd_dr !== 1'b1 || rd_level !== 4'd1) begin failures++; $display("FAIL pack_w0_latency got dr=%0b lvl=%0d exp dr=1 lvl=1", rd_dr, rd_level); end
    step(1, 1, ti[2], tq[2], 0, 0);
    step(1, 1, ti[3], tq[3], 0, 0);
    checks++; if (rd_level !== 4'd3) begin failures++; $display("FAIL pack_level got=%0d exp=3", rd_level); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (rd_data !== exp_w[k]) begin failures++; $display("FAIL pack_word%0d got=%h exp=%h", k, rd_data, exp_w[k]); end
      step(1, 0, 12'd0, 12'd0, 1, 0);
    end
    checks++; if (rd_dr !== 1'b0 || rd_level !== 4'd0) begin failures++; $display("FAIL pack_drained got dr=%0b lvl=%0d exp 0/0", rd_dr, rd_level); end
  endtask

  task automatic test_handshake();
    logic [11:0] ri[4];
    logic [11:0] rq[4];
    for (int k = 0; k < 4; k++) begin
      ri[k] = 12'($urandom);
      rq[k] = 12'($urandom);
    end
    do_reset();
    step(1, 0, 12'd0, 12'd0, 1, 0);
    checks++; if (rd_dr !== 1'b0 || rd_level !== 4'd0 || rd_data !== '0) begin failures++; $display("FAIL hs_read_empty got dr=%0b lvl=%0d data=%h exp 0/0/0", rd_dr, rd_level, rd_data); end
    step(1, 1, ri[0], rq[0], 0, 0);
    step(1, 1, ri[1], rq[1], 0, 0);
    step(1, 1, ri[2], rq[2], 1, 0);
    checks++; if (rd_level !== 4'd1) begin failures++; $display("FAIL hs_rw_level got=%0d exp=1", rd_level); end
    checks++; if (rd_data !== mq[0]) begin failures++; $display("FAIL hs_rw_next_word got=%h exp=%h", rd_data, mq[0]); end
    step(1, 1, ri[3], rq[3], 0, 0);
    checks++; if (rd_level !== 4'd2 || rd_data !== mq[0]) begin failures++; $display("FAIL hs_after got lvl=%0d data=%h exp lvl=2 data=%h", rd_level, rd_data, mq[0]); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 12; k++) step(1, 1, 12'($urandom), 12'($urandom), 0, 0);
    checks++; if (rd_level !== 4'd6) begin failures++; $display("FAIL ovf_level got=%0d exp=6", rd_level); end
    checks++; if (drop_cnt !== 16'd4) begin failures++; $display("FAIL ovf_drop_cnt got=%0d exp=4", drop_cnt); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    step(1, 0, 12'd0, 12'd0, 0, 1);
    checks++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got cnt=%0d ovf=%0b exp 0/0", drop_cnt, overflow); end
    for (int k = 0; k < 4; k++) step(1, 1, 12'($urandom), 12'($urandom), 0, 0);
    checks++; if (drop_cnt !== 16'd4) begin failures++; $display("FAIL ovf_second_group got=%0d exp=4", drop_cnt); end
    step(1, 1, 12'($urandom), 12'($urandom), 0, 1);
    checks++; if (drop_cnt !== 16'd1 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_clear_plus_drop got cnt=%0d ovf=%0b exp 1/1", drop_cnt, overflow); end
    checks++; if (rd_level !== 4'd6) begin failures++; $display("FAIL ovf_level_kept got=%0d exp=6", rd_level); end
  endtask

  task automatic test_realign();
    logic [11:0] ai;
    logic [11:0] aq;
    logic [11:0] bi;
    logic [11:0] bq;
    logic [31:0] exp_w[4];
    logic [11:0] ti[4];
    logic [11:0] tq[4];
    ti = '{12'h123, 12'h789, 12'hDEF, 12'h345};
    tq = '{12'h456, 12'hABC, 12'h012, 12'h678};
    ai = 12'($urandom); aq = 12'($urandom);
    bi = 12'($urandom); bq = 12'($urandom);
    exp_w = '{{ai, aq, bi[11:4]}, 32'h12345678, 32'h9ABCDEF0, 32'h12345678};
    do_reset();
    step(1, 1, ai, aq, 0, 0);
    step(1, 1, bi, bq, 0, 0);
    step(0, 1, 12'hFFF, 12'hFFF, 0, 0);
    checks++; if (rd_level !== 4'd1) begin failures++; $display("FAIL realign_fifo_kept got=%0d exp=1", rd_level); end
    for (int k = 0; k < 4; k++) step(1, 1, ti[k], tq[k], 0, 0);
    checks++; if (rd_level !== 4'd4) begin failures++; $display("FAIL realign_level got=%0d exp=4", rd_level); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (rd_data !== exp_w[k]) begin failures++; $display("FAIL realign_word%0d got=%h exp=%h", k, rd_data, exp_w[k]); end
      step(1, 0, 12'd0, 12'd0, 1, 0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1, 1, 12'($urandom), 12'($urandom), 0, 0);
    step(1, 1, 12'($urandom), 12'($urandom), 0, 0);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    checks++; if (rd_level !== 4'd0 || rd_dr !== 1'b0) begin failures++; $display("FAIL async_reset got lvl=%0d dr=%0b exp 0/0", rd_level, rd_dr); end
    @(negedge clk);
    rstn = 1'b1;
    step(1, 1, 12'h123, 12'h456, 0, 0);
    step(1, 1, 12'h789, 12'hABC, 0, 0);
    checks++; if (rd_data !== 32'h12345678 || rd_level !== 4'd1) begin failures++; $display("FAIL async_reset_regroup got data=%h lvl=%0d exp 12345678/1", rd_data, rd_level); end
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      step(($urandom % 16) != 0, ($urandom % 4) != 0, 12'($urandom), 12'($urandom),
           ($urandom % 3) == 0, ($urandom % 40) == 0);
      checks++;
      if (rd_level !== 4'(mq.size()) || rd_dr !== (mq.size() > 0) ||
          rd_data !== ((mq.size() > 0) ? mq[0] : 32'd0) ||
          drop_cnt !== m_drop || overflow !== m_ovf) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle%0d got lvl=%0d data=%h cnt=%0d ovf=%0b exp lvl=%0d data=%h cnt=%0d ovf=%0b",
                   n, rd_level, rd_data, drop_cnt, overflow, mq.size(),
                   (mq.size() > 0) ? mq[0] : 32'd0, m_drop, m_ovf);
      end
    end
  endtask

`ifdef IQ_PACKER_TEST_PATTERN_EN
  task automatic test_pattern();
    test_en = 1'b1;
    m_tp    = 1;
    do_reset();
    for (int k = 0; k < 4; k++) step(1, 1, 12'($urandom), 12'($urandom), 0, 0);
    checks++; if (rd_data !== 32'h000FFF00) begin failures++; $display("FAIL pattern_first_word got=%h exp=000fff00", rd_data); end
    checks++; if (rd_level !== 4'd3) begin failures++; $display("FAIL pattern_level got=%0d exp=3", rd_level); end
    step(1, 0, 12'd0, 12'd0, 1, 0);
    checks++; if (rd_data !== 32'h1FFE002F) begin failures++; $display("FAIL pattern_word1 got=%h exp=1ffe002f", rd_data); end
    step(1, 0, 12'd0, 12'd0, 1, 0);
    checks++; if (rd_data !== 32'hFD003FFC) begin failures++; $display("FAIL pattern_word2 got=%h exp=fd003ffc", rd_data); end
    test_en = 1'b0;
    m_tp    = 0;
  endtask
`endif

  initial begin
    m_tp = 0;
`ifdef IQ_PACKER_TEST_PATTERN_EN
    test_en = 1'b0;
`endif
    test_reset();
    test_packing();
    test_handshake();
    test_overflow();
    test_realign();
    test_async_reset();
`ifdef IQ_PACKER_TEST_PATTERN_EN
    test_pattern();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
